// File: rtl/adder4_arb_pkg.sv
// ============================================================================
// Module      : adder4_arb_pkg
// Description : Shared types and constants for the adder4 round-robin arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package adder4_arb_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/adder4.sv
// ============================================================================
// Module      : adder4
// Description : 4-bit combinational datapath, sum = a XOR b.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder4
    import adder4_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

    assign sum_o = a_i ^ b_i;

endmodule

`default_nettype wire

// File: rtl/adder4_arbiter.sv
// ============================================================================
// Module      : adder4_arbiter
// Description : Round-robin sharing of one adder4 among NREQ requesters with a
//               single tagged valid/ready response channel.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder4_arbiter
    import adder4_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy,
    output logic [CNTW-1:0]        ops_done
);

    // Returns {found, index} of the first valid requester at or after ptr.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx_v;
        int             idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_v = IDW'(idx);
            if (valid[idx_v]) res = {1'b1, idx_v};
        end
        return res;
    endfunction

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [IDW-1:0]      op_id_q, op_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [CNTW-1:0]     ops_done_q, ops_done_d;

    logic [DATA_W-1:0]   w_a [NREQ];
    logic [DATA_W-1:0]   w_b [NREQ];
    logic [IDW:0]        w_pick;
    logic                w_found;
    logic [IDW-1:0]      w_win;
    logic [DATA_W-1:0]   w_sum;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_a[i] = req_a[DATA_W*i +: DATA_W];
        assign w_b[i] = req_b[DATA_W*i +: DATA_W];
    end

    assign w_pick  = rr_pick(req_valid, rr_ptr_q);
    assign w_found = w_pick[IDW];
    assign w_win   = w_pick[IDW-1:0];

    adder4 u_adder4 (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (w_sum)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        ops_done_d  = ops_done_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                // Grant is withheld while reset is asserted so no requester sees a false accept.
                if (rst_n && w_found) begin
                    req_ready[w_win] = 1'b1;
                    op_a_d   = w_a[w_win];
                    op_b_d   = w_b[w_win];
                    op_id_d  = w_win;
                    rr_ptr_d = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_sum_d   = w_sum;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (ops_done_q != '1) ops_done_d = ops_done_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_done_q;

endmodule

`default_nettype wire

// File: doc/adder4_arbiter.md
Name: adder4_arbiter

Overview:
- Shares a single adder4 datapath (4-bit a, b -> 4-bit sum, sum = a XOR b, purely combinational) among NREQ requesters.
- Uses round-robin arbitration. Each requester uses a valid/ready request handshake; one shared valid/ready response channel carries the result tagged with the requester id.
- Sits between requester blocks and the adder4 instance and is the only driver of adder4 inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester id.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept (one-hot or zero)
- req_a  input  NREQ*4  operand a; requester i owns bits [4i+3:4i]
- req_b  input  NREQ*4  operand b; same packing
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  4  registered adder4 result
- rsp_id  output  IDW  index of the requester that issued the operation
- busy  output  1  high whenever state != IDLE
- ops_done  output  CNTW  count of completed responses (rsp_valid & rsp_ready), saturating

Behaviour:
- Reset (rst_n low at a clk edge) sets state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_sum 0, rsp_id 0, busy 0, ops_done 0.
- Reset mid-operation drops the in-flight transaction; no response is ever issued for it.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - The winner is the first i with req_valid[i], searching from rr_ptr upward with wrap at NREQ-1 -> 0.
  - req_ready[winner] is driven combinationally high in the same cycle. At most one req_ready bit is ever high, and only in IDLE.
  - On the handshake edge, the winner's a/b are latched into op_a/op_b, the id into op_id, rr_ptr becomes winner+1 (wrapping), and state -> EXEC.
  - With no req_valid, the FSM stays in IDLE and rr_ptr is unchanged.
- EXEC (exactly 1 cycle):
  - adder4 is driven from op_a/op_b.
  - At the edge, sum is registered into rsp_sum, op_id into rsp_id, rsp_valid is set to 1, and state -> RESP.
- RESP:
  - rsp_valid, rsp_sum and rsp_id are held stable until rsp_ready is sampled high.
  - On that edge: rsp_valid -> 0, ops_done increments (holds at all-ones), state -> IDLE.
  - No new request is accepted in RESP or EXEC. A new grant can occur at the earliest in the cycle after the response handshake.
- Latency: request handshake at edge N -> rsp_valid high after edge N+1. With rsp_ready held high, the response handshake occurs at edge N+2 and the next grant at edge N+3. Peak throughput is 1 op per 3 cycles.
- Operands are sampled only on the accept edge. Later changes on req_a/req_b do not affect the result.
- A requester that drops req_valid before being granted loses its slot silently; no error is flagged.
- Simultaneous requests are resolved purely by rr_ptr. A continuously requesting requester is granted at most once per NREQ grants while others request.
- rsp_ready is ignored while rsp_valid is 0.

Decomposition:
- Package adder4_arb_pkg holds the state enum typedef (IDLE, EXEC, RESP) and the constant DATA_W = 4.
- Single sub-module: the existing adder4, instantiated once inside adder4_arbiter.
- The round-robin priority search is a function in the same file; no separate module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, ops_done=0, busy=0 throughout.
- Single op: req_valid=4'b0100, req_a[11:8]=3, req_b[11:8]=2, rsp_ready=1 -> req_ready=4'b0100 for one cycle; rsp_valid exactly 2 edges later with rsp_sum=1, rsp_id=2; ops_done=1.
- Round-robin fairness: req_valid held at 4'b1111 with operand pairs (7,8), (14,1), (9,6), (5,10) on ids 0..3 -> grants in order 0, 1, 2, 3, 0; rsp_sum = 15, 15, 15, 15, 15; no id repeats within 4 grants.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, while other requests are pending -> rsp_sum/rsp_id stable, req_ready=0, busy=1; the next grant occurs only after rsp_ready=1.
- Reset mid-op: assert rst_n=0 in EXEC -> no rsp_valid afterwards, ops_done=0, the next grant starts from id 0.
- Counter saturation: with CNTW=2, complete 5 ops -> ops_done reads 1, 2, 3, 3, 3.
